regwrite_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback sources: A (ALU result) and B (load data from memory).
- Each source has a one-entry holding buffer with a valid/ready handshake.
- An age-aware round-robin arbiter drives a registered write_reg/wad/wd triple straight into the register file.
- Exports a busy mask of destination registers with writes still in flight, so issue logic can stall.

---
 rtl/regwrite_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_regwrite_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/regwrite_arbiter.sv
// Two-source register-file write-port arbiter with one-entry buffers, age-aware round robin
// and a busy mask. Optional macro REGWRITE_ZERO_DROP_EN drops writes to register 0.
module regwrite_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [ADDR_W-1:0]        a_addr,
  input  logic [DATA_W-1:0]        a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [ADDR_W-1:0]        b_addr,
  input  logic [DATA_W-1:0]        b_data,
  output logic                     write_reg,
  output logic [ADDR_W-1:0]        wad,
  output logic [DATA_W-1:0]        wd,
  output logic [(2**ADDR_W)-1:0]   busy_mask
);

  typedef enum logic [1:0] {
    AGE_NONE  = 2'd0,
    AGE_A_OLD = 2'd1,
    AGE_B_OLD = 2'd2
  } age_e;

  logic              a_v_r, b_v_r;
  logic [ADDR_W-1:0] a_addr_r, b_addr_r;
  logic [DATA_W-1:0] a_data_r, b_data_r;
  logic              rr_r, rr_next_s;
  age_e              age_r, age_next_s;
  logic              write_reg_r;
  logic [ADDR_W-1:0] wad_r;
  logic [DATA_W-1:0] wd_r;

  logic a_drop_s, b_drop_s;
  logic a_cand_s, b_cand_s;
  logic grant_a_s, grant_b_s;
  logic a_take_s, b_take_s;
  logic a_load_s, b_load_s;
  logic a_v_next_s, b_v_next_s;
  logic [(2**ADDR_W)-1:0] busy_s;

  // Zero-address drop detection and arbitration candidates.
  always_comb begin
    a_drop_s = 1'b0;
    b_drop_s = 1'b0;
`ifdef REGWRITE_ZERO_DROP_EN
    a_drop_s = a_v_r && (a_addr_r == {ADDR_W{1'b0}});
    b_drop_s = b_v_r && (b_addr_r == {ADDR_W{1'b0}});
`endif
    a_cand_s = a_v_r && !a_drop_s;
    b_cand_s = b_v_r && !b_drop_s;
  end

  // Grant selection: age first, round robin only on a same-edge tie.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    rr_next_s = rr_r;
    if (a_cand_s && b_cand_s) begin
      case (age_r)
        AGE_A_OLD: grant_a_s = 1'b1;
        AGE_B_OLD: grant_b_s = 1'b1;
        default: begin
          if (rr_r == 1'b0) begin
            grant_a_s = 1'b1;
            rr_next_s = 1'b1;
          end else begin
            grant_b_s = 1'b1;
            rr_next_s = 1'b0;
          end
        end
      endcase
    end else if (a_cand_s) begin
      grant_a_s = 1'b1;
    end else if (b_cand_s) begin
      grant_b_s = 1'b1;
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  // Handshake: a buffer frees up when its entry is granted or dropped in this cycle.
  always_comb begin
    a_take_s   = grant_a_s || a_drop_s;
    b_take_s   = grant_b_s || b_drop_s;
    a_ready    = rst && (!a_v_r || a_take_s);
    b_ready    = rst && (!b_v_r || b_take_s);
    a_load_s   = a_valid && a_ready;
    b_load_s   = b_valid && b_ready;
    a_v_next_s = a_load_s || (a_v_r && !a_take_s);
    b_v_next_s = b_load_s || (b_v_r && !b_take_s);
  end

  // Age next state: the entry that stays behind while the other side reloads becomes older.
  always_comb begin
    age_next_s = age_r;
    if (a_load_s && b_load_s) begin
      age_next_s = AGE_NONE;
    end else if (a_load_s && b_v_r && !b_take_s) begin
      age_next_s = AGE_B_OLD;
    end else if (b_load_s && a_v_r && !a_take_s) begin
      age_next_s = AGE_A_OLD;
    end else if (!a_v_next_s || !b_v_next_s) begin
      age_next_s = AGE_NONE;
    end else begin
      age_next_s = age_r;
    end
  end

  // Age and round-robin state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      age_r <= AGE_NONE;
      rr_r  <= 1'b0;
    end else begin
      age_r <= age_next_s;
      rr_r  <= rr_next_s;
    end
  end

  // Holding buffers for both sources.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_v_r    <= 1'b0;
      a_addr_r <= {ADDR_W{1'b0}};
      a_data_r <= {DATA_W{1'b0}};
      b_v_r    <= 1'b0;
      b_addr_r <= {ADDR_W{1'b0}};
      b_data_r <= {DATA_W{1'b0}};
    end else begin
      a_v_r <= a_v_next_s;
      b_v_r <= b_v_next_s;
      if (a_load_s) begin
        a_addr_r <= a_addr;
        a_data_r <= a_data;
      end
      if (b_load_s) begin
        b_addr_r <= b_addr;
        b_data_r <= b_data;
      end
    end
  end

  // Registered write port; address and data hold when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_reg_r <= 1'b0;
      wad_r       <= {ADDR_W{1'b0}};
      wd_r        <= {DATA_W{1'b0}};
    end else begin
      write_reg_r <= grant_a_s || grant_b_s;
      if (grant_a_s) begin
        wad_r <= a_addr_r;
        wd_r  <= a_data_r;
      end else if (grant_b_s) begin
        wad_r <= b_addr_r;
        wd_r  <= b_data_r;
      end
    end
  end

  // Busy mask from buffered candidates and the output stage only.
  always_comb begin
    busy_s = {(2**ADDR_W){1'b0}};
    if (a_cand_s) begin
      busy_s[a_addr_r] = 1'b1;
    end else begin
      busy_s = busy_s;
    end
    if (b_cand_s) begin
      busy_s[b_addr_r] = 1'b1;
    end else begin
      busy_s = busy_s;
    end
    if (write_reg_r) begin
      busy_s[wad_r] = 1'b1;
    end else begin
      busy_s = busy_s;
    end
  end

  assign write_reg = write_reg_r;
  assign wad       = wad_r;
  assign wd        = wd_r;
  assign busy_mask = busy_s;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Scoreboard bench for regwrite_arbiter: timestamp-based reference model predicts
// grants; a monitor pops expected writes whenever write_reg is seen high.
module tb_regwrite_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              a_valid = 1'b0, b_valid = 1'b0;
  logic              a_ready, b_ready;
  logic [ADDR_W-1:0] a_addr = 5'd0, b_addr = 5'd0;
  logic [DATA_W-1:0] a_data = 32'd0, b_data = 32'd0;
  logic              write_reg;
  logic [ADDR_W-1:0] wad;
  logic [DATA_W-1:0] wd;
  logic [NREG-1:0]   busy_mask;

  always #5 clk = ~clk;

  regwrite_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .write_reg(write_reg), .wad(wad), .wd(wd), .busy_mask(busy_mask)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  int  checks   = 0;
  int  failures = 0;
  wr_t exp_q[$];
  logic [DATA_W-1:0] rf [NREG];

  // Reference model: each buffered entry carries the cycle it was loaded in.
  bit                m_a_v, m_b_v, m_rr, m_out_v;
  logic [ADDR_W-1:0] m_a_addr, m_b_addr, m_out_addr;
  logic [DATA_W-1:0] m_a_data, m_b_data;
  int                m_a_ts, m_b_ts, cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic bit is_drop(input bit v, input logic [ADDR_W-1:0] addr);
`ifdef REGWRITE_ZERO_DROP_EN
    return v && (addr == 5'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_clear();
    m_a_v = 1'b0; m_b_v = 1'b0; m_rr = 1'b0; m_out_v = 1'b0;
    m_a_addr = 5'd0; m_b_addr = 5'd0; m_out_addr = 5'd0;
    m_a_data = 32'd0; m_b_data = 32'd0; m_a_ts = 0; m_b_ts = 0;
    exp_q.delete();
  endtask

  task automatic step(input bit av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                      input bit bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd,
                      output bit a_acc, output bit b_acc);
    bit a_drop, b_drop, a_c, b_c, ga, gb, tie;
    logic [NREG-1:0] mb;
    @(negedge clk);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #1;
    a_drop = is_drop(m_a_v, m_a_addr);
    b_drop = is_drop(m_b_v, m_b_addr);
    a_c = m_a_v && !a_drop;
    b_c = m_b_v && !b_drop;
    ga = 1'b0; gb = 1'b0;
    tie = a_c && b_c && (m_a_ts == m_b_ts);
    if (a_c && b_c) begin
      if (m_a_ts < m_b_ts)      ga = 1'b1;
      else if (m_b_ts < m_a_ts) gb = 1'b1;
      else if (!m_rr)           ga = 1'b1;
      else                      gb = 1'b1;
    end else begin
      ga = a_c; gb = b_c;
    end
    a_acc = av && (!m_a_v || ga || a_drop);
    b_acc = bv && (!m_b_v || gb || b_drop);
    mb = 32'd0;
    if (a_c) mb[m_a_addr] = 1'b1;
    if (b_c) mb[m_b_addr] = 1'b1;
    if (m_out_v) mb[m_out_addr] = 1'b1;
    check("a_ready", a_ready, !m_a_v || ga || a_drop);
    check("b_ready", b_ready, !m_b_v || gb || b_drop);
    check("write_reg", write_reg, m_out_v);
    check("busy_mask", busy_mask, mb);
    @(posedge clk);
    cyc++;
    if (tie) m_rr = ga;
    m_out_v = ga || gb;
    if (ga) begin
      exp_q.push_back('{addr: m_a_addr, data: m_a_data});
      m_out_addr = m_a_addr;
    end else if (gb) begin
      exp_q.push_back('{addr: m_b_addr, data: m_b_data});
      m_out_addr = m_b_addr;
    end
    if (ga || a_drop) m_a_v = 1'b0;
    if (gb || b_drop) m_b_v = 1'b0;
    if (a_acc) begin m_a_v = 1'b1; m_a_addr = aa; m_a_data = ad; m_a_ts = cyc; end
    if (b_acc) begin m_b_v = 1'b1; m_b_addr = ba; m_b_data = bd; m_b_ts = cyc; end
  endtask

  task automatic idle(input int n);
    bit x, y;
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, x, y);
  endtask

  // Monitor: every observed write must match the head of the expected queue.
  always @(negedge clk) begin
    wr_t e;
    if (rst === 1'b1 && write_reg === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write actual wad=%0h wd=%0h expected none", wad, wd);
      end else begin
        e = exp_q.pop_front();
        check("wad", wad, e.addr);
        check("wd", wd, e.data);
      end
      rf[wad] = wd;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit x, y, pa_v, pb_v;
    logic [ADDR_W-1:0] pa_a, pb_a;
    logic [DATA_W-1:0] pa_d, pb_d;
    int na, nb, iter;
    for (int i = 0; i < NREG; i++) rf[i] = 32'd0;
    model_clear();
    cyc = 0;
    #13;
    check("rst_write_reg", write_reg, 1'b0);
    check("rst_wad", wad, 5'd0);
    check("rst_wd", wd, 32'd0);
    check("rst_busy", busy_mask, 32'd0);
    check("rst_a_ready", a_ready, 1'b0);
    check("rst_b_ready", b_ready, 1'b0);
    @(negedge clk); rst = 1'b1;

    // Single write
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, x, y);
    idle(4);
    check("single_rf5", rf[5], 32'hDEADBEEF);

    // Round-robin tie, then repeated pair goes B first
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, x, y);
    idle(3);
    step(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, x, y);
    idle(3);

    // Age ordering on the same register
    step(1'b1, 5'd9, 32'd1, 1'b1, 5'd9, 32'd2, x, y);
    step(1'b1, 5'd9, 32'd3, 1'b0, 5'd0, 32'd0, x, y);
    check("age_accept", x, 1'b1);
    idle(4);
    check("age_rf9", rf[9], 32'd3);

    // Backpressure: both sources always valid
    na = 0; nb = 0; iter = 0;
    while ((na < 6 || nb < 6) && iter < 30) begin
      step(na < 6, 5'd10, 32'h100 + na, nb < 6, 5'd11, 32'h200 + nb, x, y);
      if (x) na++;
      if (y) nb++;
      iter++;
    end
    check("bp_done_a", na, 6);
    check("bp_done_b", nb, 6);
    idle(3);

    // Zero-address pair
    step(1'b1, 5'd0, 32'hFF, 1'b1, 5'd7, 32'h5, x, y);
    idle(3);

    // Reset mid-flight with both buffers valid and a write on the port
    step(1'b1, 5'd12, 32'hA1, 1'b1, 5'd13, 32'hB1, x, y);
    step(1'b1, 5'd14, 32'hA2, 1'b1, 5'd15, 32'hB2, x, y);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    check("pre_rst_write_reg", write_reg, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_write_reg", write_reg, 1'b0);
    check("mid_rst_busy", busy_mask, 32'd0);
    check("mid_rst_a_ready", a_ready, 1'b0);
    check("mid_rst_b_ready", b_ready, 1'b0);
    model_clear();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    idle(4);

    // Randomized traffic; sources hold a write until it is accepted
    pa_v = 1'b0; pb_v = 1'b0; pa_a = 5'd0; pb_a = 5'd0; pa_d = 32'd0; pb_d = 32'd0;
    for (int c = 0; c < 1500; c++) begin
      if (!pa_v && $urandom_range(0, 99) < 65) begin
        pa_v = 1'b1; pa_a = 5'($urandom_range(0, 7)); pa_d = $urandom;
      end
      if (!pb_v && $urandom_range(0, 99) < 65) begin
        pb_v = 1'b1; pb_a = 5'($urandom_range(0, 7)); pb_d = $urandom;
      end
      step(pa_v, pa_a, pa_d, pb_v, pb_a, pb_d, x, y);
      if (x) pa_v = 1'b0;
      if (y) pb_v = 1'b0;
    end
    idle(5);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
